// File: rtl/fft_spectrum_feeder.sv
// Ping-pong frame buffer between the FFT magnitude stream and the spectrum-drawing LCD block.
// Latency: data_req -> fft_data is 2 cycles (registered RAM read, then clamp register).
// Backpressure: s_ready drops once a complete frame waits for a swap; it rises again at the next display wrap.
//
// Ports:
//   lcd_pclk, rst_n        single clock domain, async active-low reset
//   h_disp                 LCD horizontal resolution; displayed magnitude is clamped to h_disp-1
//   s_valid/s_data/s_last  FFT magnitude stream in, s_ready out (valid/ready handshake)
//   data_req               1-cycle request for the magnitude at fft_point_cnt
//   fft_point_done         1-cycle pulse advancing fft_point_cnt (wraps after POINTS-1)
//   fft_point_cnt          point index currently displayed
//   fft_data               clamped magnitude, held until the next data_req
//   frame_swap, frame_err  1-cycle status pulses: banks swapped / malformed input frame dropped
module fft_spectrum_feeder #(
    parameter int POINTS = 64,
    parameter int DW     = 16
) (
    input  logic          lcd_pclk,
    input  logic          rst_n,
    input  logic [10:0]   h_disp,
    input  logic          s_valid,
    input  logic [DW-1:0] s_data,
    input  logic          s_last,
    output logic          s_ready,
    input  logic          data_req,
    input  logic          fft_point_done,
    output logic [6:0]    fft_point_cnt,
    output logic [DW-1:0] fft_data,
    output logic          frame_swap,
    output logic          frame_err
);

    localparam int          AW   = $clog2(2 * POINTS);
    localparam int          EW   = (DW > 11) ? DW : 11;
    localparam logic [6:0]  LAST = 7'(POINTS - 1);

    logic [6:0]    wr_idx_q, wr_idx_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic          pending_q, pending_d;
    logic          rd_valid_q, rd_valid_d;
    logic [6:0]    cnt_q, cnt_d;
    logic          frame_swap_q, frame_err_q;
    logic          req_q;       // read issued last cycle; clamp stage loads fft_data
    logic          rvld_q;      // rd_valid captured alongside the RAM read
    logic [DW-1:0] fft_data_q, fft_data_d;
    logic [DW-1:0] rdata_q;

    logic [DW-1:0] mem [0:2*POINTS-1];

    logic          accept, at_last, beat_ok, beat_bad, wrap, swap;
    logic [AW-1:0] waddr, raddr;
    logic [EW-1:0] word_ext, lim_ext, clamped;

    assign s_ready  = ~pending_q;
    assign accept   = s_valid & ~pending_q;
    assign at_last  = (wr_idx_q == LAST);
    assign beat_ok  = accept & (s_last == at_last);
    assign beat_bad = accept & (s_last != at_last);
    assign wrap     = fft_point_done & (cnt_q == LAST);
    // Uses the registered pending: a frame finishing in the wrap cycle waits for the next wrap.
    assign swap     = wrap & pending_q;

    // Bank b occupies addresses [b*POINTS, b*POINTS+POINTS-1]; POINTS need not be a power of two.
    assign waddr = AW'(wr_idx_q) + (wr_bank_q ? AW'(POINTS) : AW'(0));
    assign raddr = AW'(cnt_q)    + (rd_bank_q ? AW'(POINTS) : AW'(0));

    // Clamp on the zero-extended word, so set bits above bit 10 always saturate to h_disp-1.
    always_comb begin
        word_ext = EW'(rdata_q);
        lim_ext  = EW'(h_disp - 11'd1);
        clamped  = '0;
        if (rvld_q && (h_disp != 11'd0)) begin
            clamped = (word_ext > lim_ext) ? lim_ext : word_ext;
        end
    end

    always_comb begin
        wr_idx_d   = wr_idx_q;
        wr_bank_d  = wr_bank_q;
        rd_bank_d  = rd_bank_q;
        pending_d  = pending_q;
        rd_valid_d = rd_valid_q | swap;
        cnt_d      = cnt_q;
        fft_data_d = fft_data_q;

        if (beat_ok) begin
            wr_idx_d = at_last ? 7'd0 : wr_idx_q + 7'd1;
        end else if (beat_bad) begin
            wr_idx_d = 7'd0;
        end

        // swap needs pending_q=1 and a completing beat needs pending_q=0, so these never collide.
        if (swap) begin
            pending_d = 1'b0;
            wr_bank_d = rd_bank_q;
            rd_bank_d = wr_bank_q;
        end else if (beat_ok && at_last) begin
            pending_d = 1'b1;
        end

        if (fft_point_done) begin
            cnt_d = (cnt_q == LAST) ? 7'd0 : cnt_q + 7'd1;
        end

        if (req_q) begin
            fft_data_d = DW'(clamped);
        end
    end

    always_ff @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_idx_q     <= '0;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b1;
            pending_q    <= 1'b0;
            rd_valid_q   <= 1'b0;
            cnt_q        <= '0;
            frame_swap_q <= 1'b0;
            frame_err_q  <= 1'b0;
            req_q        <= 1'b0;
            rvld_q       <= 1'b0;
            fft_data_q   <= '0;
        end else begin
            wr_idx_q     <= wr_idx_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            pending_q    <= pending_d;
            rd_valid_q   <= rd_valid_d;
            cnt_q        <= cnt_d;
            frame_swap_q <= swap;
            frame_err_q  <= beat_bad;
            req_q        <= data_req;
            if (data_req) begin
                rvld_q <= rd_valid_q;
            end
            fft_data_q   <= fft_data_d;
        end
    end

    // Simple dual-port RAM: one write port, one registered read port, contents not reset.
    always_ff @(posedge lcd_pclk) begin
        if (beat_ok) begin
            mem[waddr] <= s_data;
        end
        if (data_req) begin
            rdata_q <= mem[raddr];
        end
    end

    assign fft_point_cnt = cnt_q;
    assign fft_data      = fft_data_q;
    assign frame_swap    = frame_swap_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_fft_spectrum_feeder.sv
module tb_fft_spectrum_feeder;

    localparam int P = 64;

    logic        lcd_pclk = 1'b0;
    logic        rst_n    = 1'b0;
    logic [10:0] h_disp;
    logic        s_valid, s_last, s_ready;
    logic [15:0] s_data;
    logic        data_req, fft_point_done;
    logic [6:0]  fft_point_cnt;
    logic [15:0] fft_data;
    logic        frame_swap, frame_err;

    fft_spectrum_feeder #(.POINTS(P), .DW(16)) dut (
        .lcd_pclk      (lcd_pclk),
        .rst_n         (rst_n),
        .h_disp        (h_disp),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_last        (s_last),
        .s_ready       (s_ready),
        .data_req      (data_req),
        .fft_point_done(fft_point_done),
        .fft_point_cnt (fft_point_cnt),
        .fft_data      (fft_data),
        .frame_swap    (frame_swap),
        .frame_err     (frame_err)
    );

    always #5 lcd_pclk = ~lcd_pclk;

    int          total = 0;
    int          bad   = 0;
    int          exp_cnt = 0;
    logic [15:0] fbuf     [P];
    logic [15:0] pend_buf [P];
    logic [15:0] shown    [P];
    bit          shown_vld = 1'b0;
    logic [15:0] sbq [$];
    logic        rq1, rq2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int clampf(input int w, input int hd);
        if (hd == 0) return 0;
        if (w > hd - 1) return hd - 1;
        return w;
    endfunction

    // Bench-side view of the 2-cycle read pipeline: pop the scoreboard when data should land.
    always @(posedge lcd_pclk or negedge rst_n) begin
        if (!rst_n) begin
            rq1 <= 1'b0;
            rq2 <= 1'b0;
        end else begin
            rq1 <= data_req;
            rq2 <= rq1;
        end
    end

    always @(negedge lcd_pclk) begin
        if (rq2 && rst_n) begin
            chk("sb_has_entry", 32'(sbq.size() > 0), 32'd1);
            if (sbq.size() > 0) chk("fft_data", 32'(fft_data), 32'(sbq.pop_front()));
        end
    end

    task automatic tick();
        @(posedge lcd_pclk);
        #1;
    endtask

    task automatic req();
        data_req = 1'b1;
        sbq.push_back(shown_vld ? 16'(clampf(int'(shown[exp_cnt]), int'(h_disp))) : 16'd0);
        tick();
        data_req = 1'b0;
        tick();
        tick();
        tick();
    endtask

    task automatic pulse_done(input bit exp_swap);
        int was;
        was = exp_cnt;
        fft_point_done = 1'b1;
        tick();
        fft_point_done = 1'b0;
        exp_cnt = (was == P - 1) ? 0 : was + 1;
        @(negedge lcd_pclk);
        chk("point_cnt", 32'(fft_point_cnt), 32'(exp_cnt));
        chk("frame_swap", 32'(frame_swap), 32'((was == P - 1) && exp_swap));
        if (was == P - 1 && exp_swap) begin
            shown     = pend_buf;
            shown_vld = 1'b1;
        end
        tick();
    endtask

    task automatic goto_cnt(input int n);
        while (exp_cnt != n) pulse_done(1'b0);
    endtask

    task automatic go_wrap(input bit exp_swap);
        while (exp_cnt != P - 1) pulse_done(1'b0);
        pulse_done(exp_swap);
    endtask

    // Sends n beats from fbuf with s_last on beat last_at; anything but a clean
    // 64-beat frame is expected to end in a frame_err pulse on its final beat.
    task automatic send_frame(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            int cyc;
            s_valid = 1'b1;
            s_data  = fbuf[i];
            s_last  = (i == last_at);
            cyc = 0;
            @(negedge lcd_pclk);
            while (!s_ready && cyc < 2000) begin
                @(negedge lcd_pclk);
                cyc++;
            end
            chk("beat_ready", 32'(s_ready), 32'd1);
            @(posedge lcd_pclk);
            #1;
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        if (n == P && last_at == P - 1) begin
            @(negedge lcd_pclk);
            chk("s_ready_after_last", 32'(s_ready), 32'd0);
            chk("no_err_good_frame", 32'(frame_err), 32'd0);
            pend_buf = fbuf;
        end else begin
            @(negedge lcd_pclk);
            chk("frame_err_pulse", 32'(frame_err), 32'd1);
            tick();
            @(negedge lcd_pclk);
            chk("frame_err_drop", 32'(frame_err), 32'd0);
            chk("s_ready_after_err", 32'(s_ready), 32'd1);
            tick();
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_cnt"},   32'(fft_point_cnt), 32'd0);
        chk({tag, "_data"},  32'(fft_data),      32'd0);
        chk({tag, "_ready"}, 32'(s_ready),       32'd1);
        chk({tag, "_swap"},  32'(frame_swap),    32'd0);
        chk({tag, "_err"},   32'(frame_err),     32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        h_disp = 11'd800;
        s_valid = 1'b0; s_data = '0; s_last = 1'b0;
        data_req = 1'b0; fft_point_done = 1'b0;
        repeat (3) tick();
        @(negedge lcd_pclk);
        chk_reset_outputs("reset");
        tick();
        rst_n = 1'b1;
        tick();

        // T1: empty display reads zero, a full wrap without pending frame does not swap
        req();
        go_wrap(1'b0);

        // T2: ramp frame, swap at next wrap
        for (int i = 0; i < P; i++) fbuf[i] = 16'(10 * i);
        send_frame(P, P - 1);
        go_wrap(1'b1);
        @(negedge lcd_pclk);
        chk("s_ready_after_swap", 32'(s_ready), 32'd1);
        tick();
        goto_cnt(5);  req();
        goto_cnt(63); req();

        // T3: clamping to h_disp-1, including upper magnitude bits and h_disp=0
        h_disp = 11'd480;
        for (int i = 0; i < P; i++) fbuf[i] = 16'(5 * i);
        fbuf[7] = 16'd1000;
        fbuf[8] = 16'hF005;
        send_frame(P, P - 1);
        go_wrap(1'b1);
        goto_cnt(7); req();
        goto_cnt(8); req();
        goto_cnt(9); req();
        h_disp = 11'd0;
        req();
        h_disp = 11'd480;

        // T4: early s_last and missing s_last both drop the frame; display unchanged
        for (int i = 0; i < P; i++) fbuf[i] = 16'(9 * i);
        send_frame(11, 10);
        go_wrap(1'b0);
        goto_cnt(7); req();
        send_frame(P, -1);
        go_wrap(1'b0);
        goto_cnt(9); req();

        // T5: back-to-back frames; second stalls until the first swap
        for (int i = 0; i < P; i++) fbuf[i] = 16'(3 * i + 1);
        send_frame(P, P - 1);
        for (int i = 0; i < P; i++) fbuf[i] = 16'(7 * i + 2);
        fork
            send_frame(P, P - 1);
            go_wrap(1'b1);
        join
        goto_cnt(10); req();
        go_wrap(1'b1);
        goto_cnt(3);  req();
        goto_cnt(63); req();

        // T6: reset in the middle of an input frame with a frame on display
        for (int i = 0; i < 30; i++) begin
            s_valid = 1'b1;
            s_data  = 16'(100 + i);
            s_last  = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        #2;
        chk_reset_outputs("midreset");
        tick();
        s_valid = 1'b0;
        tick();
        rst_n = 1'b1;
        exp_cnt = 0;
        shown_vld = 1'b0;
        sbq.delete();
        tick();
        req();
        goto_cnt(3); req();
        go_wrap(1'b0);
        req();
        for (int i = 0; i < P; i++) fbuf[i] = 16'(11 * i + 3);
        send_frame(P, P - 1);
        go_wrap(1'b1);
        goto_cnt(4); req();

        chk("sb_drained", 32'(sbq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
